uart_tx_arbiter: RTL

Round-robin scheduler that shares the single transmitter of the `UART` block between `NUM_REQ` byte producers. It accepts one byte at a time from the granted requester and drives the UART's `iT`/`iTDATA` start handshake. It then waits for the UART's `oT` frame-finished pulse, or for a watchdog timeout, before serving the next requester. It sits directly in front of `UART.iT`/`UART.iTDATA` and consumes `UART.oT`.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Issues a start pulse per granted byte, then waits for frame-finished or a watchdog abort.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 2048,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [NUM_REQ-1:0]   iREQ,
  input  logic [8*NUM_REQ-1:0] iDATA,
  output logic [NUM_REQ-1:0]   oACK,
  output logic [NUM_REQ-1:0]   oDONE,
  output logic                 oERR,
  output logic [2:0]           oERR_ID,
  output logic                 oBUSY,
  output logic                 oT,
  output logic [7:0]           oTDATA,
  input  logic                 iTFIN
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit HasGap = (GAP_CYCLES != 0);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);
  localparam logic [7:0]      GapLast = 8'(GAP_CYCLES - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

  state_e          state_q;
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] gnt_q;
  logic [WdW-1:0]  wdog_q;
  logic [7:0]      gap_q;

  logic            found;
  logic [PtrW-1:0] sel;
  logic [PtrW-1:0] cand;
  int unsigned     idx;
  logic            frame_end;

  // First asserted request at or after ptr_q, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PtrW'(idx);
      if (!found && iREQ[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // A finish pulse coinciding with expiry wins over the abort.
  assign frame_end = iTFIN || (wdog_q == WdLast);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wdog_q  <= '0;
      gap_q   <= '0;
      oACK    <= '0;
      oDONE   <= '0;
      oERR    <= 1'b0;
      oERR_ID <= 3'd0;
      oBUSY   <= 1'b0;
      oT      <= 1'b0;
      oTDATA  <= 8'h00;
    end else begin
      oACK  <= '0;
      oDONE <= '0;
      oERR  <= 1'b0;
      oT    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            oTDATA  <= iDATA[{sel, 3'b000} +: 8];
            oACK    <= NUM_REQ'(1) << sel;
            oT      <= 1'b1;
            gnt_q   <= sel;
            ptr_q   <= (sel == PtrLast) ? '0 : sel + 1'b1;
            wdog_q  <= '0;
            oBUSY   <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (frame_end) begin
            if (iTFIN) begin
              oDONE <= NUM_REQ'(1) << gnt_q;
            end else begin
              oERR    <= 1'b1;
              oERR_ID <= 3'(gnt_q);
            end
            if (HasGap) begin
              gap_q   <= '0;
              state_q <= StGap;
            end else begin
              oBUSY   <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            oBUSY   <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          oBUSY   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
